// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a shared single-ported memory
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iDone,
  output logic [DATA_W-1:0] iRData,
  output logic              iStall,
  input  logic              dReq,
  input  logic              dWr,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic              dDone,
  output logic [DATA_W-1:0] dRData,
  output logic              dStall,
  output logic              memEn,
  output logic              memWr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData
);

  localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  state_t              nextState;
  logic                ownerData;   // 1 = data stage owns the transaction
  logic                latWr;
  logic [LAT_W-1:0]    latCnt;
  logic [STARVE_W-1:0] starveCnt;
  logic [DATA_W-1:0]   rdData;
  logic                grantAny;
  logic                grantData;
  logic                starved;

  assign starved = (starveCnt == STARVE_W'(STARVE_MAX));

  // State register; reset abandons any in-flight access without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state, arbitration decision and memory strobes
  always_comb begin
    nextState = state;
    grantAny  = 1'b0;
    grantData = 1'b0;
    memEn     = 1'b0;
    memWr     = 1'b0;
    case (state)
      IDLE: begin
        if (iReq || dReq) begin
          grantAny  = 1'b1;
          // data normally wins; a starved fetch takes the next slot
          grantData = dReq && !(iReq && starved);
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        memEn     = 1'b1;
        memWr     = latWr;
        nextState = WAIT;
      end
      WAIT: begin
        if (latCnt == '0) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Transaction latches, latency counter, starvation counter and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerData <= 1'b0;
      latWr     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      latCnt    <= '0;
      starveCnt <= '0;
      rdData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantAny) begin
            ownerData <= grantData;
            latWr     <= grantData & dWr;
            memAddr   <= grantData ? dAddr : iAddr;
            memWData  <= grantData ? dWData : '0;
            if (!grantData)
              starveCnt <= '0;
            else if (iReq && !starved)
              starveCnt <= starveCnt + 1'b1;
          end
        end
        ISSUE: latCnt <= LAT_W'(MEM_LAT - 1);
        WAIT: begin
          if (latCnt == '0)
            rdData <= latWr ? '0 : memRData;
          else
            latCnt <= latCnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign iDone  = (state == DONE) && !ownerData;
  assign dDone  = (state == DONE) && ownerData;
  assign iRData = iDone ? rdData : '0;
  assign dRData = dDone ? rdData : '0;
  // gated by rst so the stalls collapse together with everything else
  assign iStall = iReq & ~iDone & ~rst;
  assign dStall = dReq & ~dDone & ~rst;

endmodule
